// File: rtl/bram_burst_reader.sv
// Streams a burst of consecutive BRAM words onto a valid/ready stream with a last marker.
// Reads are credit-limited so the output FIFO can always absorb every word still in flight.
module bram_burst_reader #(
   parameter  int RAM_WIDTH  = 18,
   parameter  int RAM_DEPTH  = 1024,
   parameter  int LATENCY    = 2,
   parameter  int FIFO_DEPTH = 4,
   localparam int ADDR_W     = $clog2(RAM_DEPTH)
) (
   input  logic                 clka,
   input  logic                 rstb,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      length,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic                 mem_regce,
   output logic                 mem_rst,
   input  logic [RAM_WIDTH-1:0] mem_dout,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_valid,
   output logic                 m_last,
   input  logic                 m_ready
);

   localparam int LEN_W = ADDR_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int INF_W = $clog2(LATENCY + 1);
   localparam int SUM_W = $clog2(FIFO_DEPTH + LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    rem_q;
   logic                busy_q;
   logic                done_q;
   logic [LATENCY-1:0]  tag_q;
   logic [LATENCY-1:0]  tag_last_q;

   logic [RAM_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic                 fifo_last_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;

   logic [INF_W-1:0]    inflight;
   logic                credit_ok;
   logic                issue;
   logic                push;
   logic                pop;
   logic [LEN_W-1:0]    len_clamped;
   logic [ADDR_W-1:0]   addr_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + INF_W'(tag_q[i]);
      end
      // Credit uses registered occupancy only; a same-cycle pop frees nothing yet.
      credit_ok   = (SUM_W'(inflight) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH);
      issue       = (state_q == S_ISSUE) && credit_ok;
      push        = tag_q[LATENCY-1];
      pop         = m_valid && m_ready;
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      len_clamped = (length > LEN_W'(RAM_DEPTH)) ? LEN_W'(RAM_DEPTH) : length;
      addr_d      = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
   end

   always_ff @(posedge clka) begin
      if (rstb) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q  <= base_addr;
                  rem_q   <= len_clamped;
                  busy_q  <= 1'b1;
                  // Zero-length requests pass through DRAIN, which exits at once when empty.
                  state_q <= (len_clamped == '0) ? S_DRAIN : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue) begin
                  addr_q <= addr_d;
                  rem_q  <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if ((pop && m_last) || (inflight == '0 && count_q == '0)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clka) begin
      if (rstb) begin
         tag_q      <= '0;
         tag_last_q <= '0;
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            tag_q[i]      <= tag_q[i-1];
            tag_last_q[i] <= tag_last_q[i-1];
         end
         tag_q[0]      <= issue;
         tag_last_q[0] <= issue && (rem_q == LEN_W'(1));
      end
   end

   always_ff @(posedge clka) begin
      if (rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_dout;
            fifo_last_q[wr_ptr_q] <= tag_last_q[LATENCY-1];
            wr_ptr_q              <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clka) begin
      if (!rstb) begin
         assert (!(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));
         assert (!(pop && count_q == '0));
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_addr  = addr_q;
   assign mem_en    = issue;
   assign mem_we    = 1'b0;
   assign mem_regce = 1'b1;
   assign mem_rst   = rstb;
   assign m_valid   = (count_q != '0);
   assign m_data    = fifo_data_q[rd_ptr_q];
   assign m_last    = m_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: BRAM model with 2-cycle latency and a queue-based
// reference of the expected word stream for each burst.
module tb_bram_burst_reader;

   localparam int RAM_WIDTH  = 18;
   localparam int RAM_DEPTH  = 1024;
   localparam int LATENCY    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = $clog2(RAM_DEPTH);

   logic                 clka = 1'b0;
   logic                 rstb;
   logic                 start;
   logic [ADDR_W-1:0]    base_addr;
   logic [ADDR_W:0]      length;
   logic                 busy;
   logic                 done;
   logic [ADDR_W-1:0]    mem_addr;
   logic                 mem_en;
   logic                 mem_we;
   logic                 mem_regce;
   logic                 mem_rst;
   logic [RAM_WIDTH-1:0] mem_dout;
   logic [RAM_WIDTH-1:0] m_data;
   logic                 m_valid;
   logic                 m_last;
   logic                 m_ready;

   int checks = 0;
   int errors = 0;

   logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_s1;

   always #5 clka = ~clka;

   bram_burst_reader #(
      .RAM_WIDTH (RAM_WIDTH),
      .RAM_DEPTH (RAM_DEPTH),
      .LATENCY   (LATENCY),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clka     (clka),
      .rstb     (rstb),
      .start    (start),
      .base_addr(base_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .mem_addr (mem_addr),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_regce(mem_regce),
      .mem_rst  (mem_rst),
      .mem_dout (mem_dout),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_last   (m_last),
      .m_ready  (m_ready)
   );

   // BRAM port: latch on enable, then output register; data not cleared by reset.
   always @(posedge clka) begin
      if (mem_en) ram_s1 <= ram[mem_addr];
      if (mem_regce) mem_dout <= ram_s1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_burst(input int b, input int l, input int pct, input int inject_rel);
      logic [RAM_WIDTH-1:0] exp_q [$];
      logic [RAM_WIDTH-1:0] e;
      int  n, issued, beats, last_rel, first_valid_rel, rel;
      bit  got_done, prev_stall;
      n = (l > RAM_DEPTH) ? RAM_DEPTH : l;
      for (int k = 0; k < n; k++) exp_q.push_back(ram[(b + k) % RAM_DEPTH]);
      issued = 0; beats = 0; last_rel = -1; first_valid_rel = -1;
      got_done = 1'b0; prev_stall = 1'b0;
      start = 1'b1; base_addr = ADDR_W'(b); length = (ADDR_W+1)'(l);
      for (rel = 1; rel <= 40 * n + 60 && !got_done; rel++) begin
         @(negedge clka);
         start = (rel == inject_rel);
         if (rel == inject_rel) begin
            base_addr = ADDR_W'(500);
            length    = (ADDR_W+1)'(5);
         end
         if (mem_en) begin
            check("issue_addr", mem_addr, (b + issued) % RAM_DEPTH);
            issued++;
            check("credit_limit", (issued - beats) <= FIFO_DEPTH, 1);
         end
         if (pct >= 100) begin
            check("en_window", mem_en, rel <= n);
            check("valid_window", m_valid, (rel >= LATENCY + 2) && (rel <= n + LATENCY + 1));
         end
         if (prev_stall) check("stall_hold", m_valid, 1);
         if (m_valid && first_valid_rel < 0) begin
            first_valid_rel = rel;
            check("first_valid_rel", rel, LATENCY + 2);
         end
         if (m_valid && exp_q.size() > 0) check("valid_data", m_data, exp_q[0]);
         m_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", m_data, e);
               check("beat_last", m_last, exp_q.size() == 0);
               if (exp_q.size() == 0) last_rel = rel;
            end
            beats++;
         end
         prev_stall = m_valid && !m_ready;
         if (done) begin
            got_done = 1'b1;
            check("done_rel", rel, (n == 0) ? 2 : last_rel + 1);
            check("issued_total", issued, n);
            check("beats_total", beats, n);
         end else begin
            check("busy_during", busy, 1);
         end
      end
      if (!got_done) check("done_timeout", 0, 1);
      @(negedge clka);
      check("busy_after", busy, 0);
      check("done_after", done, 0);
      $display("burst base=%0d len=%0d ready_pct=%0d issued=%0d beats=%0d", b, l, pct, issued, beats);
   endtask

   initial begin
      int cnt;
      rstb = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] = RAM_WIDTH'(i);
      repeat (3) @(negedge clka);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_data", m_data, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_regce", mem_regce, 1);
      check("rst_mem_rst", mem_rst, 1);
      rstb = 1'b0;
      @(negedge clka);
      check("run_mem_rst", mem_rst, 0);

      do_burst(16, 8, 100, -1);
      do_burst(0, 32, 50, -1);
      do_burst(1020, 8, 100, -1);
      do_burst(7, 0, 100, -1);
      do_burst(300, 2000, 100, -1);
      do_burst(200, 16, 100, 6);
      do_burst(40, 16, 100, 18);

      // Abort a 16-word burst after five beats have gone out.
      start = 1'b1; base_addr = ADDR_W'(0); length = (ADDR_W+1)'(16);
      cnt = 0;
      for (int c = 0; c < 100 && cnt < 5; c++) begin
         @(negedge clka);
         start = 1'b0; m_ready = 1'b1;
         if (m_valid) begin
            check("pre_rst_data", m_data, cnt);
            cnt++;
         end
      end
      check("pre_rst_beats", cnt, 5);
      @(negedge clka);
      rstb = 1'b1;
      @(negedge clka);
      rstb = 1'b0;
      check("post_rst_valid", m_valid, 0);
      check("post_rst_busy", busy, 0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clka);
         check("late_valid", m_valid, 0);
         check("late_en", mem_en, 0);
      end
      $display("reset abort after %0d beats", cnt);
      do_burst(100, 4, 100, -1);

      for (int i = 0; i < RAM_DEPTH; i++) ram[i] = RAM_WIDTH'($urandom);
      for (int t = 0; t < 6; t++) begin
         do_burst(int'($urandom_range(0, RAM_DEPTH - 1)), int'($urandom_range(1, 48)),
                  int'($urandom_range(25, 100)), -1);
      end
      do_burst(1000, 40, 60, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
